lpc_target_mux: RTL
===================

LPC_TARGET_MUX -- requirements
Module: lpc_target_mux

Interface
REQ-001 SHALL have parameter BASE0..BASE3, 16-bit, defaults 16'h0080/16'h0060/16'h0064/16'h03F8, target k address window base.
REQ-002 SHALL have parameter MASK0..MASK3, 16-bit, defaults 16'hFFFF/16'hFFFF/16'hFFFF/16'hFFF8, target k compare mask (1 = bit compared).
REQ-003 SHALL have parameter TIMEOUT, 8-bit, default 8'd200, maximum cycles waiting for a target ack.
REQ-004 SHALL have ports: one clock; reset is asynchronous and active-low.
REQ-005 clk_i  in  1  LPC clock, all logic on rising edge.
REQ-006 nrst_i  in  1  asynchronous active-low reset.
REQ-007 lpc_addr_i  in  16  I/O address from LPC peripheral.
REQ-008 lpc_data_io  inout  8  write data from peripheral; driven by this block only in RD_HOLD, else high-Z.
REQ-009 lpc_data_wr_i  in  1  peripheral has valid write data (level).
REQ-010 lpc_wr_done_o  out  1  write consumed.
REQ-011 lpc_data_req_i  in  1  peripheral requests read data (level).
REQ-012 lpc_data_rd_o  out  1  read data valid on lpc_data_io.
REQ-013 tgt_addr_o  out  16  latched address; tgt_wdata_o  out  8  latched write data.
REQ-014 tgt_wr_o / tgt_rd_o  out  4  one-hot per-target strobes; tgt_ack_i  in  4  per-target ack; tgt_rdata_i  in  32  target k data in bits [8k+7:8k].
REQ-015 err_o  out  1  sticky timeout flag; err_clr_i  in  1  synchronous clear of err_o.

Function
REQ-016 SHALL implement states IDLE, WR_REQ, WR_WAIT, WR_DONE, RD_REQ, RD_WAIT, RD_HOLD.
REQ-017 SHALL register lpc_data_wr_i and lpc_data_req_i and detect 0->1 edges; a level held across reset SHALL NOT start a transaction.
REQ-018 IDLE: write edge -> WR_REQ latching lpc_addr_i and lpc_data_io; read edge -> RD_REQ latching lpc_addr_i; simultaneous edges -> write wins, read edge discarded.
REQ-019 Target k matches when (addr & MASKk) == (BASEk & MASKk); multiple matches -> lowest k wins; decode result registered in WR_REQ/RD_REQ.
REQ-020 WR_REQ with match: tgt_wr_o[k] high exactly one cycle, then WR_WAIT; no match: straight to WR_DONE (write discarded, no error).
REQ-021 WR_WAIT: tgt_ack_i[k] -> WR_DONE; acks from non-selected targets ignored.
REQ-022 WR_DONE: lpc_wr_done_o high, held until lpc_data_wr_i samples 0, then IDLE.
REQ-023 RD_REQ with match: tgt_rd_o[k] high one cycle, then RD_WAIT; no match: read data 8'hFF, go to RD_HOLD.
REQ-024 RD_WAIT: tgt_ack_i[k] -> capture tgt_rdata_i[8k+7:8k] same edge, go to RD_HOLD.
REQ-025 RD_HOLD: drive captured byte on lpc_data_io, lpc_data_rd_o high, held until lpc_data_req_i samples 0, then IDLE and release bus.
REQ-026 Timeout: 8-bit counter cleared on entering WR_WAIT/RD_WAIT, increments each wait cycle; reaching TIMEOUT without ack -> set err_o, write goes WR_DONE, read returns 8'hFF via RD_HOLD.
REQ-027 Ack on the same cycle counter reaches TIMEOUT SHALL count as success, err_o unchanged.
REQ-028 Abort: lpc_data_wr_i (write states) or lpc_data_req_i (read states) sampled 0 before WR_DONE/RD_HOLD -> IDLE next cycle, strobes low, no done/rd pulse, err_o unchanged.
REQ-029 err_o set and err_clr_i same cycle -> set wins.
REQ-030 Latency: write edge to tgt_wr_o = 2 cycles; ack to lpc_wr_done_o/lpc_data_rd_o = 1 cycle.

Reset
REQ-031 nrst_i low SHALL immediately force IDLE, all outputs 0 (tgt_addr_o 16'h0000, tgt_wdata_o 8'h00, strobes 4'b0000, lpc_wr_done_o 0, lpc_data_rd_o 0, err_o 0), lpc_data_io high-Z, counter and edge registers 0, including mid-transaction.

Verification
REQ-032 Write 0x80 data 0x5A, target0 acks 3 cycles after strobe -> tgt_wr_o=4'b0001 one cycle, tgt_wdata_o=0x5A, lpc_wr_done_o held until lpc_data_wr_i falls.
REQ-033 Read 0x3FB, target3 acks with 0xC3 -> tgt_rd_o=4'b1000, lpc_data_io=0xC3 with lpc_data_rd_o until lpc_data_req_i falls.
REQ-034 Read 0x0100 (no match) -> no strobe, lpc_data_io=0xFF, err_o stays 0.
REQ-035 Write 0x64, target2 never acks -> after 200 wait cycles err_o=1, lpc_wr_done_o=1; err_clr_i pulse -> err_o=0.
REQ-036 lpc_data_req_i drops during RD_WAIT, later late ack -> IDLE, lpc_data_rd_o never asserted, ack ignored.
REQ-037 nrst_i low during RD_HOLD -> lpc_data_io high-Z and all outputs 0 same instant; no new transaction while lpc_data_req_i remains high after reset.

Source files
------------

// File: rtl/lpc_target_mux_if.sv
// Bus bundle between the LPC peripheral, lpc_target_mux and its four I/O targets.
// The bidirectional LPC data byte stays a plain inout port on the mux itself.
interface lpc_target_mux_if;
  logic [15:0] lpc_addr_i;
  logic        lpc_data_wr_i;
  logic        lpc_wr_done_o;
  logic        lpc_data_req_i;
  logic        lpc_data_rd_o;
  logic [15:0] tgt_addr_o;
  logic [7:0]  tgt_wdata_o;
  logic [3:0]  tgt_wr_o;
  logic [3:0]  tgt_rd_o;
  logic [3:0]  tgt_ack_i;
  logic [31:0] tgt_rdata_i;
  logic        err_o;
  logic        err_clr_i;

  modport slave (
    input  lpc_addr_i, lpc_data_wr_i, lpc_data_req_i, tgt_ack_i, tgt_rdata_i, err_clr_i,
    output lpc_wr_done_o, lpc_data_rd_o, tgt_addr_o, tgt_wdata_o, tgt_wr_o, tgt_rd_o, err_o
  );

  modport master (
    output lpc_addr_i, lpc_data_wr_i, lpc_data_req_i, tgt_ack_i, tgt_rdata_i, err_clr_i,
    input  lpc_wr_done_o, lpc_data_rd_o, tgt_addr_o, tgt_wdata_o, tgt_wr_o, tgt_rd_o, err_o
  );
endinterface

// File: rtl/lpc_target_mux.sv
// Routes LPC I/O cycles to one of four address-decoded targets with ack timeout
// and a sticky error flag.
//
// state   | meaning
// IDLE    | waiting for a write or read request edge
// WR_REQ  | decode latched address, pulse target write strobe
// WR_WAIT | waiting for selected target ack (or timeout/abort)
// WR_DONE | lpc_wr_done_o high until peripheral drops write request
// RD_REQ  | decode latched address, pulse target read strobe
// RD_WAIT | waiting for selected target ack (or timeout/abort)
// RD_HOLD | captured byte driven on lpc_data_io until read request drops
module lpc_target_mux #(
  parameter logic [15:0] BASE0   = 16'h0080,
  parameter logic [15:0] BASE1   = 16'h0060,
  parameter logic [15:0] BASE2   = 16'h0064,
  parameter logic [15:0] BASE3   = 16'h03F8,
  parameter logic [15:0] MASK0   = 16'hFFFF,
  parameter logic [15:0] MASK1   = 16'hFFFF,
  parameter logic [15:0] MASK2   = 16'hFFFF,
  parameter logic [15:0] MASK3   = 16'hFFF8,
  parameter logic [7:0]  TIMEOUT = 8'd200
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  inout  wire  [7:0]        lpc_data_io,
  lpc_target_mux_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_WAIT, WR_DONE, RD_REQ, RD_WAIT, RD_HOLD
  } state_t;

  state_t      state;
  logic        armed_q;
  logic        wr_s, wr_d, req_s, req_d;
  logic        wr_rise, req_rise;
  logic [7:0]  cnt_q;
  logic [7:0]  rdata_q;
  logic [1:0]  sel_q;
  logic        data_oe_q;
  logic        hit;
  logic [1:0]  hit_idx;
  logic        ack_sel;
  logic [7:0]  byte_sel;

  assign lpc_data_io = data_oe_q ? rdata_q : 8'bz;

  // Right after reset the delayed copy follows the raw input, so a level
  // already high when reset releases never looks like a rising edge.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      armed_q <= 1'b0;
      wr_s    <= 1'b0;
      wr_d    <= 1'b0;
      req_s   <= 1'b0;
      req_d   <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      wr_s    <= bus.lpc_data_wr_i;
      req_s   <= bus.lpc_data_req_i;
      wr_d    <= armed_q ? wr_s  : bus.lpc_data_wr_i;
      req_d   <= armed_q ? req_s : bus.lpc_data_req_i;
    end
  end

  assign wr_rise  = wr_s & ~wr_d;
  assign req_rise = req_s & ~req_d;

  // Evaluated highest index first so the lowest matching target wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 2'd0;
    if ((bus.tgt_addr_o & MASK3) == (BASE3 & MASK3)) begin
      hit = 1'b1; hit_idx = 2'd3;
    end
    if ((bus.tgt_addr_o & MASK2) == (BASE2 & MASK2)) begin
      hit = 1'b1; hit_idx = 2'd2;
    end
    if ((bus.tgt_addr_o & MASK1) == (BASE1 & MASK1)) begin
      hit = 1'b1; hit_idx = 2'd1;
    end
    if ((bus.tgt_addr_o & MASK0) == (BASE0 & MASK0)) begin
      hit = 1'b1; hit_idx = 2'd0;
    end
  end

  assign ack_sel  = bus.tgt_ack_i[sel_q];
  assign byte_sel = bus.tgt_rdata_i[{sel_q, 3'b000} +: 8];

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state             <= IDLE;
      bus.tgt_addr_o    <= 16'h0000;
      bus.tgt_wdata_o   <= 8'h00;
      bus.tgt_wr_o      <= 4'b0000;
      bus.tgt_rd_o      <= 4'b0000;
      bus.lpc_wr_done_o <= 1'b0;
      bus.lpc_data_rd_o <= 1'b0;
      bus.err_o         <= 1'b0;
      cnt_q             <= 8'd0;
      sel_q             <= 2'd0;
      rdata_q           <= 8'h00;
      data_oe_q         <= 1'b0;
    end else begin
      bus.tgt_wr_o <= 4'b0000;
      bus.tgt_rd_o <= 4'b0000;
      // A timeout below overrides this, so set beats clear.
      if (bus.err_clr_i) bus.err_o <= 1'b0;

      case (state)
        IDLE: begin
          if (wr_rise) begin
            bus.tgt_addr_o  <= bus.lpc_addr_i;
            bus.tgt_wdata_o <= lpc_data_io;
            state           <= WR_REQ;
          end else if (req_rise) begin
            bus.tgt_addr_o  <= bus.lpc_addr_i;
            state           <= RD_REQ;
          end
        end

        WR_REQ: begin
          if (!bus.lpc_data_wr_i) begin
            state <= IDLE;
          end else if (hit) begin
            sel_q        <= hit_idx;
            bus.tgt_wr_o <= 4'b0001 << hit_idx;
            cnt_q        <= 8'd0;
            state        <= WR_WAIT;
          end else begin
            bus.lpc_wr_done_o <= 1'b1;
            state             <= WR_DONE;
          end
        end

        WR_WAIT: begin
          if (!bus.lpc_data_wr_i) begin
            state <= IDLE;
          end else if (ack_sel) begin
            bus.lpc_wr_done_o <= 1'b1;
            state             <= WR_DONE;
          end else if (cnt_q == TIMEOUT - 8'd1) begin
            bus.err_o         <= 1'b1;
            bus.lpc_wr_done_o <= 1'b1;
            state             <= WR_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        WR_DONE: begin
          if (!bus.lpc_data_wr_i) begin
            bus.lpc_wr_done_o <= 1'b0;
            state             <= IDLE;
          end
        end

        RD_REQ: begin
          if (!bus.lpc_data_req_i) begin
            state <= IDLE;
          end else if (hit) begin
            sel_q        <= hit_idx;
            bus.tgt_rd_o <= 4'b0001 << hit_idx;
            cnt_q        <= 8'd0;
            state        <= RD_WAIT;
          end else begin
            rdata_q           <= 8'hFF;
            bus.lpc_data_rd_o <= 1'b1;
            data_oe_q         <= 1'b1;
            state             <= RD_HOLD;
          end
        end

        RD_WAIT: begin
          if (!bus.lpc_data_req_i) begin
            state <= IDLE;
          end else if (ack_sel) begin
            rdata_q           <= byte_sel;
            bus.lpc_data_rd_o <= 1'b1;
            data_oe_q         <= 1'b1;
            state             <= RD_HOLD;
          end else if (cnt_q == TIMEOUT - 8'd1) begin
            bus.err_o         <= 1'b1;
            rdata_q           <= 8'hFF;
            bus.lpc_data_rd_o <= 1'b1;
            data_oe_q         <= 1'b1;
            state             <= RD_HOLD;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        RD_HOLD: begin
          if (!bus.lpc_data_req_i) begin
            bus.lpc_data_rd_o <= 1'b0;
            data_oe_q         <= 1'b0;
            state             <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
